// File: rtl/spi_flash_burst_rd_if.sv
// rtl/spi_flash_burst_rd_if.sv - request and read-word bus bundle for spi_flash_burst_rd
interface spi_flash_burst_rd_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;

    modport master (
        output req_valid, req_addr, req_len, rd_ready,
        input  req_ready, rd_valid, rd_data, rd_last, busy
    );

    modport slave (
        input  req_valid, req_addr, req_len, rd_ready,
        output req_ready, rd_valid, rd_data, rd_last, busy
    );
endinterface

// File: rtl/spi_flash_burst_rd.sv
// rtl/spi_flash_burst_rd.sv - SPI mode-0 flash burst reader streaming little-endian words
// SPI_FLASH_FAST_READ_EN selects the 0x0B fast-read command with an 8-period dummy phase.
module spi_flash_burst_rd #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int CLK_DIV = 2,
    parameter int CS_HIGH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    spi_flash_burst_rd_if.slave  bus,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 cs_n
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] RD_CMD = 8'h0B;
`else
    localparam logic [7:0] RD_CMD = 8'h03;
`endif

    localparam int TX_W   = 8 + ADDR_W;
    localparam int MAX_PH = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W  = $clog2(MAX_PH + 1);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W  = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_HIGH > 0) ? CS_HIGH - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        HOLD,
        GAP
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [DIV_W-1:0]   div_cnt;
    logic               sclk_r;
    logic [CNT_W-1:0]   bit_cnt;
    logic               mosi_r;
    logic               cs_n_r;
    logic [TX_W-1:0]    tx_sr;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   word_cnt;
    logic [6:0]         rx_byte;
    logic [DATA_W-1:0]  word_r;
    logic               rd_valid_r;
    logic               rd_last_r;
    logic [GAP_W-1:0]   gap_cnt;

    logic               active;
    logic               tick;
    logic               rise;
    logic               fall;
    logic [CNT_W-1:0]   phase_len;
    logic               phase_done;
    logic               accept;
    logic               handshake;
    logic               more;
    logic               byte_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A phase ends on the falling edge that follows its last rising edge,
    // so sclk is always low when the state changes.
    always_comb begin
        active     = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
        tick       = active && (div_cnt == DIV_LAST);
        rise       = tick && !sclk_r;
        fall       = tick && sclk_r;
        case (state)
            CMD, DUMMY: phase_len = CNT_W'(8);
            ADDR:       phase_len = CNT_W'(ADDR_W);
            default:    phase_len = CNT_W'(DATA_W);
        endcase
        phase_done = fall && (bit_cnt == phase_len);
        accept     = (state == IDLE) && bus.req_valid;
        handshake  = (state == HOLD) && rd_valid_r && bus.rd_ready;
        more       = (word_cnt != len_r);
        byte_done  = rise && (state == DATA) && (bit_cnt[2:0] == 3'd7);

        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = CMD;
            CMD:   if (phase_done) state_nx = ADDR;
            ADDR: begin
                if (phase_done) begin
`ifdef SPI_FLASH_FAST_READ_EN
                    state_nx = DUMMY;
`else
                    state_nx = DATA;
`endif
                end
            end
            DUMMY: if (phase_done) state_nx = DATA;
            DATA:  if (phase_done) state_nx = HOLD;
            HOLD:  if (handshake) state_nx = more ? DATA : GAP;
            GAP:   if (gap_cnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt    <= '0;
            sclk_r     <= 1'b0;
            bit_cnt    <= '0;
            mosi_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            tx_sr      <= '0;
            len_r      <= '0;
            word_cnt   <= '0;
            rx_byte    <= '0;
            word_r     <= '0;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            div_cnt <= (!active || tick) ? '0 : div_cnt + 1'b1;
            if (tick) begin
                sclk_r <= ~sclk_r;
            end

            if (!active || phase_done) begin
                bit_cnt <= '0;
            end else if (rise) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // Command and address share one shift register; the next bit is
            // presented on each falling edge so it is stable across the rise.
            if (accept) begin
                tx_sr    <= {RD_CMD, bus.req_addr};
                mosi_r   <= RD_CMD[7];
                len_r    <= bus.req_len;
                word_cnt <= '0;
                cs_n_r   <= 1'b0;
            end else if (fall) begin
                tx_sr  <= tx_sr << 1;
                mosi_r <= ((state == CMD) || ((state == ADDR) && !phase_done)) ? tx_sr[TX_W-2] : 1'b0;
            end

            if (rise && (state == DATA)) begin
                rx_byte <= {rx_byte[5:0], miso};
            end
            // Completed bytes enter at the top and shift down, leaving the
            // first flash byte in bits [7:0] once the word is full.
            if (byte_done) begin
                word_r <= (word_r >> 8) | (DATA_W'({rx_byte, miso}) << (DATA_W - 8));
            end

            if ((state == DATA) && phase_done) begin
                rd_valid_r <= 1'b1;
                rd_last_r  <= !more;
            end else if (handshake) begin
                rd_valid_r <= 1'b0;
                rd_last_r  <= 1'b0;
                if (more) begin
                    word_cnt <= word_cnt + 1'b1;
                end else begin
                    cs_n_r <= 1'b1;
                end
            end

            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    assign sclk          = sclk_r;
    assign mosi          = mosi_r;
    assign cs_n          = cs_n_r;
    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_last   = rd_last_r;
    assign bus.rd_data   = word_r;

endmodule

// File: tb/tb_spi_flash_burst_rd.sv
// tb/tb_spi_flash_burst_rd.sv - three-divider bench for spi_flash_burst_rd with a byte-level flash model
module tb_spi_flash_burst_rd;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 8;
    localparam int CS_HIGH = 4;
    localparam int NDUT    = 3;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] EXP_CMD = 8'h0B;
    localparam int HDR = 8 + ADDR_W + 8;
`else
    localparam logic [7:0] EXP_CMD = 8'h03;
    localparam int HDR = 8 + ADDR_W;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic              req_valid [NDUT];
    logic [ADDR_W-1:0] req_addr  [NDUT];
    logic [LEN_W-1:0]  req_len   [NDUT];
    logic              rd_ready  [NDUT];
    wire               w_req_ready [NDUT];
    wire               w_rd_valid  [NDUT];
    wire [DATA_W-1:0]  w_rd_data   [NDUT];
    wire               w_rd_last   [NDUT];
    wire               w_busy      [NDUT];
    wire               w_sclk      [NDUT];
    wire               w_mosi      [NDUT];
    wire               w_cs_n      [NDUT];
    wire [31:0]        w_rcnt      [NDUT];
    wire [7:0]         w_cmd       [NDUT];
    wire [ADDR_W-1:0]  w_addr      [NDUT];
    wire [31:0]        w_per       [NDUT];
    wire [31:0]        w_bad       [NDUT];

    logic [7:0] flash_mem [int];

    function automatic logic [7:0] flash_byte(input logic [ADDR_W-1:0] a);
        int v;
        v = int'(a);
        if (flash_mem.exists(v)) return flash_mem[v];
        return 8'((v * 29) ^ (v >>> 8) ^ 8'h5A);
    endfunction

    function automatic logic flash_bit(input logic [ADDR_W-1:0] a, input int n);
        logic [7:0] b;
        b = flash_byte(ADDR_W'(a + n / 8));
        return b[7 - (n % 8)];
    endfunction

    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a, input int i);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < DATA_W / 8; k++) w[8*k +: 8] = flash_byte(ADDR_W'(a + i * (DATA_W / 8) + k));
        return w;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        spi_flash_burst_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
        wire  sclk;
        wire  mosi;
        wire  cs_n;
        logic miso = 1'b0;
        int   rcnt = 0;
        int   dbit = 0;
        int   t1 = 0;
        int   t2 = 0;
        int   mosi_bad = 0;
        int   glitch = 0;
        logic sclk_q = 1'b0;
        logic cs_q = 1'b1;
        logic [63:0]       hdr = '0;
        logic [7:0]        cmd_seen = '0;
        logic [ADDR_W-1:0] addr_seen = '0;

        assign bus.req_valid = req_valid[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_len   = req_len[g];
        assign bus.rd_ready  = rd_ready[g];
        assign w_req_ready[g] = bus.req_ready;
        assign w_rd_valid[g]  = bus.rd_valid;
        assign w_rd_data[g]   = bus.rd_data;
        assign w_rd_last[g]   = bus.rd_last;
        assign w_busy[g]      = bus.busy;
        assign w_sclk[g]      = sclk;
        assign w_mosi[g]      = mosi;
        assign w_cs_n[g]      = cs_n;
        assign w_rcnt[g]      = 32'(rcnt);
        assign w_cmd[g]       = cmd_seen;
        assign w_addr[g]      = addr_seen;
        assign w_per[g]       = 32'(t2 - t1);
        assign w_bad[g]       = 32'(mosi_bad + glitch);

        spi_flash_burst_rd #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(DIV), .CS_HIGH(CS_HIGH)
        ) dut (
            .clk(clk), .rstn(rstn), .bus(bus), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
        );

        // Flash: capture header bits on rising sclk, present data bits on falling sclk.
        always @(cs_n or sclk) begin
            if (cs_q === 1'b1 && cs_n === 1'b0) begin
                rcnt = 0;
                dbit = 0;
                hdr  = '0;
            end else if (cs_n === 1'b0 && sclk_q === 1'b0 && sclk === 1'b1) begin
                hdr  = {hdr[62:0], mosi};
                rcnt = rcnt + 1;
                if (rcnt == 1) t1 = cyc;
                if (rcnt == 2) t2 = cyc;
                if (rcnt == 8) cmd_seen = hdr[7:0];
                if (rcnt == 8 + ADDR_W) addr_seen = hdr[ADDR_W-1:0];
                if (rcnt > 8 + ADDR_W && rcnt <= HDR && mosi !== 1'b0) mosi_bad = mosi_bad + 1;
            end else if (cs_n === 1'b0 && sclk_q === 1'b1 && sclk === 1'b0 && rcnt >= HDR) begin
                miso = flash_bit(addr_seen, dbit);
                dbit = dbit + 1;
            end
            sclk_q = sclk;
            cs_q   = cs_n;
        end

        always @(mosi) if (sclk === 1'b1) glitch = glitch + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_burst(input int d, input logic [ADDR_W-1:0] addr, input int len,
                             input int stall_word, input int stall_n, input bit poke);
        int waitc;
        int gap;
        int bad;
        int div;
        div = (d == 0) ? 2 : ((d == 1) ? 1 : 4);
        @(negedge clk);
        check("req_ready_idle", 64'(w_req_ready[d]), 64'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        req_len[d]   = LEN_W'(len);
        @(negedge clk);
        req_valid[d] = 1'b0;
        check("busy_after_accept", 64'(w_busy[d]), 64'd1);
        if (poke) begin
            waitc = 0;
            while (w_rcnt[d] < 32'(HDR + 4) && waitc < 5000) begin
                @(negedge clk);
                waitc++;
            end
            check("poke_reach_data", 64'(waitc < 5000), 64'd1);
            req_valid[d] = 1'b1;
            req_addr[d]  = ~addr;
            req_len[d]   = '0;
            repeat (3) begin
                @(negedge clk);
                check("req_ready_busy", 64'(w_req_ready[d]), 64'd0);
            end
            req_valid[d] = 1'b0;
        end
        for (int i = 0; i <= len; i++) begin
            waitc = 0;
            while (w_rd_valid[d] !== 1'b1 && waitc < 4000) begin
                @(negedge clk);
                waitc++;
            end
            check("word_timeout", 64'(waitc < 4000), 64'd1);
            check("rd_data", 64'(w_rd_data[d]), 64'(exp_word(addr, i)));
            check("rd_last", 64'(w_rd_last[d]), 64'(i == len));
            if (i == stall_word) begin
                bad = 0;
                repeat (stall_n) begin
                    @(negedge clk);
                    if (w_sclk[d] !== 1'b0 || w_cs_n[d] !== 1'b0 || w_rd_valid[d] !== 1'b1) bad++;
                end
                check("stall_hold", 64'(bad), 64'd0);
            end
            rd_ready[d] = 1'b1;
            @(negedge clk);
            rd_ready[d] = 1'b0;
            check("rd_valid_drop", 64'(w_rd_valid[d]), 64'd0);
        end
        gap = 0;
        bad = 0;
        while (w_busy[d] === 1'b1 && gap < 100) begin
            if (w_cs_n[d] !== 1'b1) bad++;
            gap++;
            @(negedge clk);
        end
        check("gap_cycles", 64'(gap), 64'(CS_HIGH));
        check("gap_cs_n", 64'(bad), 64'd0);
        check("cmd_byte", 64'(w_cmd[d]), 64'(EXP_CMD));
        check("addr_sent", 64'(w_addr[d]), 64'(addr));
        check("rise_count", 64'(w_rcnt[d]), 64'(HDR + DATA_W * (len + 1)));
        check("sclk_period", 64'(w_per[d]), 64'(2 * div));
        check("mosi_stable", 64'(w_bad[d]), 64'd0);
    endtask

    initial begin
        int waitc;
        int d;
        int len;
        for (int i = 0; i < NDUT; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            req_len[i]   = '0;
            rd_ready[i]  = 1'b0;
        end
        flash_mem[32'h100] = 8'hA1;
        flash_mem[32'h101] = 8'hB2;
        flash_mem[32'h102] = 8'hC3;
        flash_mem[32'h103] = 8'hD4;
        for (int i = 0; i < 16; i++) flash_mem[32'h1000 + i] = 8'(i);

        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("rst_cs_n", 64'(w_cs_n[i]), 64'd1);
            check("rst_sclk", 64'(w_sclk[i]), 64'd0);
            check("rst_mosi", 64'(w_mosi[i]), 64'd0);
            check("rst_rd_valid", 64'(w_rd_valid[i]), 64'd0);
            check("rst_rd_last", 64'(w_rd_last[i]), 64'd0);
            check("rst_rd_data", 64'(w_rd_data[i]), 64'd0);
            check("rst_busy", 64'(w_busy[i]), 64'd0);
            check("rst_req_ready", 64'(w_req_ready[i]), 64'd1);
        end
        rstn = 1'b1;

        run_burst(0, 24'h000100, 0, -1, 0, 1'b0);
        check("single_word_value", 64'(w_rd_data[0]), 64'hD4C3B2A1);
        run_burst(0, 24'h001000, 3, 1, 20, 1'b0);
        check("burst_last_value", 64'(w_rd_data[0]), 64'h0F0E0D0C);
        run_burst(1, 24'h001004, 1, 0, 5, 1'b0);
        run_burst(2, 24'h000102, 1, 1, 7, 1'b0);
        run_burst(0, 24'h002000, 2, -1, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            d   = int'($urandom_range(0, NDUT - 1));
            len = int'($urandom_range(0, 4));
            run_burst(d, ADDR_W'($urandom), len, int'($urandom_range(0, len)), int'($urandom_range(0, 15)), 1'b0);
        end

        run_burst(1, 24'hFFFF80, (1 << LEN_W) - 1, 100, 3, 1'b0);

`ifdef SPI_FLASH_FAST_READ_EN
        run_burst(0, 24'h000000, 0, -1, 0, 1'b0);
        check("fast_rise_total", 64'(w_rcnt[0]), 64'd72);
`endif

        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 24'h00ABCD;
        req_len[0]   = LEN_W'(2);
        @(negedge clk);
        req_valid[0] = 1'b0;
        waitc = 0;
        while (w_rcnt[0] < 32'd12 && waitc < 1000) begin
            @(negedge clk);
            waitc++;
        end
        check("reach_addr_phase", 64'(waitc < 1000), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_cs_n", 64'(w_cs_n[0]), 64'd1);
        check("midrst_sclk", 64'(w_sclk[0]), 64'd0);
        check("midrst_busy", 64'(w_busy[0]), 64'd0);
        check("midrst_req_ready", 64'(w_req_ready[0]), 64'd1);
        check("midrst_rd_valid", 64'(w_rd_valid[0]), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_burst(0, 24'h001008, 1, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
